// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, keeps one imem read in flight, buffers returned
// words in a small FIFO for decode, and flushes on redirect. Define IFU_PERF_EN for perf counters.
module ifu_fetch #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(32'h80000000)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fault_o,
`ifdef IFU_PERF_EN
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt,
`endif
    output logic [1:0]        dbg_state
);

    // Handshakes: a request transfers on a posedge with valid && ready; once valid rises, valid and
    // addr hold until that edge. Responses have no ready. Decode pops on inst_valid_o && inst_ready_i.

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] hold_addr_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              discard_q;

    logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];
    logic              buf_err_q  [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              outstanding;
    logic [CNT_W:0]    occupancy;
    logic              space;
    logic              full;
    logic              req_fire;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] redirect_target;
    logic              unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Slots already committed: buffered words plus the one read still in flight.
    assign outstanding = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, outstanding};
    assign space       = occupancy < (CNT_W + 1)'(BUF_DEPTH);
    assign full        = count_q == CNT_W'(BUF_DEPTH);

    assign req_fire = imem_req_valid && imem_req_ready;
    assign push     = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid && !full;
    assign pop      = inst_valid_o && inst_ready_i && !redirect_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // A request that left before or during a redirect returns stale data.
                if (req_fire) begin
                    state_d = (redirect_valid || discard_q) ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rsp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = (state_q == ST_REQ) && (space || discard_q);
        imem_req_addr  = discard_q ? hold_addr_q : fetch_pc_q;
        dbg_state      = state_q;
    end

    // Fetch pointer and pending-request bookkeeping
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            hold_addr_q   <= '0;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
            end else if (req_fire && !discard_q) begin
                fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
            end

            if (req_fire) begin
                discard_q     <= 1'b0;
                inflight_pc_q <= imem_req_addr;
            end else if ((state_q == ST_REQ) && redirect_valid && imem_req_valid) begin
                // Keep presenting the old address; its data is dropped once it returns.
                discard_q   <= 1'b1;
                hold_addr_q <= imem_req_addr;
            end
        end
    end

    // Instruction FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_pc_q[i]   <= '0;
                buf_err_q[i]  <= 1'b0;
            end
        end else if (redirect_valid) begin
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= imem_rsp_data;
                buf_pc_q[wr_ptr_q]   <= inflight_pc_q;
                buf_err_q[wr_ptr_q]  <= imem_rsp_err;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign inst_valid_o = count_q != '0;
    assign inst_o       = buf_data_q[rd_ptr_q];
    assign inst_pc_o    = buf_pc_q[rd_ptr_q];
    assign inst_fault_o = buf_err_q[rd_ptr_q];

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (pop) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if ((state_q == ST_REQ) && imem_req_valid && !imem_req_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: models instruction memory and checks decode sees the sequential
// instruction stream restarting at each redirect target.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h80000000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_fault_o;
    logic [1:0]  unused_dbg_state;

    int checks = 0;
    int errors = 0;

    // memory model
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_dly = 0;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          ready_force = 1'b0;
    bit          ready_rand = 1'b0;
    int          err_mode = 0;

    // reference stream
    logic [31:0] exp_pc = RESET_PC;
    int          acc_cnt = 0;
    int          delivered = 0;
    int          faults_seen = 0;
    logic [31:0] last_acc_addr = '0;
    bit          accepted_now = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_acc = 1'b0;
    logic        prev_rst = 1'b0;
    logic [31:0] prev_addr = '0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid_o   (inst_valid_o),
        .inst_ready_i   (inst_ready_i),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_fault_o   (inst_fault_o),
        .dbg_state      (unused_dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic err_on(input logic [31:0] a);
        if (err_mode == 1) return a == 32'h80000004;
        if (err_mode == 2) return a[4:2] == 3'd5;
        return 1'b0;
    endfunction

    // One clock: drive memory at the negedge, check at +1, advance the models at the posedge.
    task automatic tick();
        logic        rsp_now, acc, r, rv;
        logic [31:0] acc_addr, rpc;
        rsp_now        = pend && (pend_dly == 0);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(pend_addr) : 32'h0;
        imem_rsp_err   = rsp_now ? err_on(pend_addr) : 1'b0;
        if (ready_force || (pend && !rsp_now)) imem_req_ready = 1'b0;
        else if (ready_rand) imem_req_ready = ($urandom_range(0, 3) != 0);
        else imem_req_ready = 1'b1;
        #1;
        if (rst && prev_rst && prev_valid && !prev_acc) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_stable: got valid=%b addr=%h, required valid=1 addr=%h",
                         imem_req_valid, imem_req_addr, prev_addr);
            end
        end
        if (rst && imem_req_valid === 1'b1) begin
            checks++;
            if (imem_req_addr[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL req_align: got addr=%h, required word aligned", imem_req_addr);
            end
        end
        if (rst && !redirect_valid && inst_valid_o === 1'b1 && inst_ready_i) begin
            checks += 3;
            if (inst_pc_o !== exp_pc) begin
                errors++;
                $display("FAIL sb_pc: got %h required %h", inst_pc_o, exp_pc);
            end
            if (inst_o !== mem_word(exp_pc)) begin
                errors++;
                $display("FAIL sb_inst: got %h required %h", inst_o, mem_word(exp_pc));
            end
            if (inst_fault_o !== err_on(exp_pc)) begin
                errors++;
                $display("FAIL sb_fault: got %b required %b at pc %h", inst_fault_o, err_on(exp_pc), exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
            delivered++;
            if (inst_fault_o === 1'b1) faults_seen++;
        end
        acc        = rst && (imem_req_valid === 1'b1) && imem_req_ready;
        acc_addr   = imem_req_addr;
        prev_valid = rst && (imem_req_valid === 1'b1);
        prev_addr  = imem_req_addr;
        prev_acc   = acc;
        prev_rst   = rst;
        r   = rst;
        rv  = redirect_valid;
        rpc = redirect_pc;
        @(posedge clk);
        if (rsp_now) pend = 1'b0;
        else if (pend) pend_dly--;
        accepted_now = acc;
        if (acc) begin
            pend          = 1'b1;
            pend_addr     = acc_addr;
            pend_dly      = $urandom_range(lat_min, lat_max);
            acc_cnt++;
            last_acc_addr = acc_addr;
        end
        if (!r) exp_pc = RESET_PC;
        else if (rv) exp_pc = {rpc[31:2], 2'b00};
        @(negedge clk);
    endtask

    task automatic wait_accept(input int max_cycles, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!accepted_now && n < max_cycles);
        checks++;
        if (!accepted_now) begin
            errors++;
            $display("FAIL %s: got no accepted request in %0d cycles, required one", tag, max_cycles);
        end
    endtask

    task automatic wait_inst(input int max_cycles, input string tag);
        int n = 0;
        while (inst_valid_o !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL %s: got inst_valid_o=0 after %0d cycles, required 1", tag, max_cycles);
        end
    endtask

    task automatic do_reset(input logic rdy);
        redirect_valid = 1'b0;
        inst_ready_i   = rdy;
        ready_force    = 1'b0;
        ready_rand     = 1'b0;
        rst            = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        lat_min = 0; lat_max = 0; err_mode = 0;
        redirect_valid = 1'b0; inst_ready_i = 1'b1; rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({imem_req_valid, inst_valid_o, inst_fault_o} !== 3'b000 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rv=%b iv=%b f=%b inst=%h pc=%h, required all 0",
                     imem_req_valid, inst_valid_o, inst_fault_o, inst_o, inst_pc_o);
        end
        rst = 1'b1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: got %b required 0", imem_req_valid);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL first_req: got valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL early_valid: got %b required 0", inst_valid_o);
        end
        tick();
        checks++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== RESET_PC || inst_o !== mem_word(RESET_PC)) begin
            errors++; $display("FAIL first_inst: got v=%b pc=%h inst=%h required 1 %h %h",
                               inst_valid_o, inst_pc_o, inst_o, RESET_PC, mem_word(RESET_PC));
        end
        tick();
        wait_inst(10, "second_inst_wait");
        checks++;
        if (inst_pc_o !== 32'h80000004) begin
            errors++; $display("FAIL second_inst: got pc=%h required 80000004", inst_pc_o);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        lat_min = 0; lat_max = 0; err_mode = 0;
        do_reset(1'b0);
        a0 = acc_cnt;
        repeat (20) tick();
        checks++;
        if (acc_cnt - a0 != 2) begin
            errors++; $display("FAIL bp_req_count: got %0d required 2", acc_cnt - a0);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_req_valid: got %b required 0", imem_req_valid);
        end
        checks++;
        if (inst_valid_o !== 1'b1 || inst_o !== mem_word(RESET_PC) || inst_pc_o !== RESET_PC) begin
            errors++; $display("FAIL bp_head: got v=%b inst=%h pc=%h required 1 %h %h",
                               inst_valid_o, inst_o, inst_pc_o, mem_word(RESET_PC), RESET_PC);
        end
        inst_ready_i = 1'b1;
        repeat (20) tick();
        checks++;
        if (acc_cnt - a0 <= 4) begin
            errors++; $display("FAIL bp_resume: got %0d requests required more than 4", acc_cnt - a0);
        end
    endtask

    task automatic test_redirect_wait();
        lat_min = 2; lat_max = 2; err_mode = 0;
        do_reset(1'b1);
        wait_accept(20, "rw_first_accept");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000102;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid_o !== 1'b0) begin
            errors++; $display("FAIL rw_flush: got inst_valid_o=%b required 0", inst_valid_o);
        end
        wait_accept(20, "rw_next_accept");
        checks++;
        if (last_acc_addr !== 32'h80000100) begin
            errors++; $display("FAIL rw_req_addr: got %h required 80000100", last_acc_addr);
        end
        wait_inst(20, "rw_inst_wait");
        checks++;
        if (inst_pc_o !== 32'h80000100) begin
            errors++; $display("FAIL rw_inst_pc: got %h required 80000100", inst_pc_o);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] held;
        int n = 0;
        lat_min = 0; lat_max = 0; err_mode = 0;
        do_reset(1'b1);
        repeat (8) tick();
        ready_force = 1'b1;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        held = imem_req_addr;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80000040;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== held) begin
                errors++; $display("FAIL rs_hold: got valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, held);
            end
            tick();
        end
        ready_force = 1'b0;
        wait_accept(10, "rs_old_accept");
        checks++;
        if (last_acc_addr !== held) begin
            errors++; $display("FAIL rs_old_addr: got %h required %h", last_acc_addr, held);
        end
        wait_accept(20, "rs_new_accept");
        checks++;
        if (last_acc_addr !== 32'h80000040) begin
            errors++; $display("FAIL rs_new_addr: got %h required 80000040", last_acc_addr);
        end
        wait_inst(20, "rs_inst_wait");
        checks++;
        if (inst_pc_o !== 32'h80000040) begin
            errors++; $display("FAIL rs_inst_pc: got %h required 80000040", inst_pc_o);
        end
    endtask

    task automatic test_fault();
        int f0, d0;
        lat_min = 0; lat_max = 0; err_mode = 1;
        do_reset(1'b1);
        f0 = faults_seen;
        d0 = delivered;
        repeat (25) tick();
        checks++;
        if (faults_seen - f0 != 1) begin
            errors++; $display("FAIL fault_count: got %0d required 1", faults_seen - f0);
        end
        checks++;
        if (delivered - d0 < 5) begin
            errors++; $display("FAIL fault_continue: got %0d delivered required at least 5", delivered - d0);
        end
        err_mode = 0;
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3; err_mode = 0;
        do_reset(1'b1);
        repeat (12) tick();
        wait_accept(20, "rm_accept");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if ({imem_req_valid, inst_valid_o, inst_fault_o} !== 3'b000 || inst_o !== 32'h0 || inst_pc_o !== 32'h0) begin
            errors++;
            $display("FAIL rm_outputs: got rv=%b iv=%b f=%b inst=%h pc=%h, required all 0",
                     imem_req_valid, inst_valid_o, inst_fault_o, inst_o, inst_pc_o);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            errors++; $display("FAIL rm_req: got valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
        end
        wait_inst(40, "rm_inst_wait");
        checks++;
        if (inst_pc_o !== RESET_PC) begin
            errors++; $display("FAIL rm_inst_pc: got %h required %h", inst_pc_o, RESET_PC);
        end
        lat_min = 0; lat_max = 0;
    endtask

    task automatic test_random();
        int d0;
        lat_min = 0; lat_max = 3; err_mode = 2;
        do_reset(1'b1);
        ready_rand = 1'b1;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            inst_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                case ($urandom_range(0, 3))
                    0:       redirect_pc = 32'hFFFFFFF8;
                    1:       redirect_pc = RESET_PC + ($urandom_range(0, 255) << 2);
                    default: redirect_pc = $urandom;
                endcase
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        ready_rand     = 1'b0;
        checks++;
        if (delivered - d0 < 150) begin
            errors++; $display("FAIL rand_progress: got %0d delivered required at least 150", delivered - d0);
        end
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready_i   = 1'b0;
        @(negedge clk);
        test_reset();
        test_backpressure();
        test_redirect_wait();
        test_redirect_stall();
        test_fault();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
